// File: rtl/sme_param_if.sv
// Bus bundle for sme_param: text/pattern ROM ports, mode input and match outputs.
interface sme_param_if #(
  parameter int TAW = 12,
  parameter int PAW = 7,
  parameter int PNW = 4
);
  logic           case_insensitive;
  logic [TAW-1:0] T_addr;
  logic [7:0]     T_data;
  logic [PAW-1:0] P_addr;
  logic [7:0]     P_data;
  logic           valid;
  logic [PNW-1:0] pattern_no;
  logic [TAW-1:0] match_addr;
  logic           finish;

  modport slave (
    input  case_insensitive, T_data, P_data,
    output T_addr, P_addr, valid, pattern_no, match_addr, finish
  );

  modport master (
    output case_insensitive, T_data, P_data,
    input  T_addr, P_addr, valid, pattern_no, match_addr, finish
  );
endinterface

// File: rtl/sme_param.sv
// Multi-pattern string match engine: loads each pattern from ROM, then slides it over the text.
// Optional macro SME_WILDCARD_EN makes pattern byte '.' match any non-zero text byte.
module sme_param #(
  parameter int TAW  = 12,
  parameter int PAW  = 7,
  parameter int PNW  = 4,
  parameter int PLEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  sme_param_if.slave  bus
);

  localparam int LW = $clog2(PLEN + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [TAW-1:0] t_addr_q, t_addr_d;
  logic [PAW-1:0] p_addr_q, p_addr_d;
  logic [PNW-1:0] pat_idx_q, pat_idx_d;
  logic [PNW-1:0] pno_q, pno_d;
  logic [TAW-1:0] maddr_q, maddr_d;
  logic           valid_q, valid_d;
  logic           finish_q, finish_d;
  logic           ci_q, ci_d;
  logic           first_q, first_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  fill_q, fill_nx;
  logic [7:0]     win_q  [PLEN];
  logic [7:0]     win_d  [PLEN];
  logic [7:0]     pbuf_q [PLEN];
  logic [7:0]     pbuf_d [PLEN];

  logic [PLEN-1:0] eq_vec;
  logic            shift_en, load_shift, scan_first, hit, text_end;
  logic [TAW-1:0]  cap_addr;

  function automatic logic byte_eq(input logic [7:0] p, input logic [7:0] t, input logic ci);
    logic [7:0] pf, tf;
    logic       eq;
    pf = p;
    tf = t;
    if (ci && p >= 8'h41 && p <= 8'h5A) pf = p | 8'h20;
    if (ci && t >= 8'h41 && t <= 8'h5A) tf = t | 8'h20;
    eq = (pf == tf);
`ifdef SME_WILDCARD_EN
    if (p == 8'h2E) eq = (t != 8'h00);
`endif
    byte_eq = eq;
  endfunction

  // Address of the text byte arriving now: T_addr advances every scan cycle.
  assign cap_addr   = t_addr_q - TAW'(1);
  assign scan_first = (state_q == S_SCAN) && first_q;
  assign shift_en   = (state_q == S_SCAN) && !first_q && (bus.T_data != 8'h00);
  assign text_end   = (state_q == S_SCAN) && !first_q &&
                      ((bus.T_data == 8'h00) || (cap_addr == {TAW{1'b1}}));
  assign load_shift = (state_q == S_LOAD) && !first_q && (bus.P_data != 8'h00);
  assign fill_nx    = scan_first ? '0 :
                      (shift_en && fill_q < len_q) ? fill_q + LW'(1) : fill_q;

  // Pattern buffer is loaded newest-first, so pbuf[j] lines up with win[j].
  generate
    for (genvar gi = 0; gi < PLEN; gi++) begin : g_pos
      localparam logic [LW-1:0] POS = LW'(gi);
      if (gi == 0) begin : g_head
        assign win_d[gi]  = scan_first ? 8'h00 : shift_en ? bus.T_data : win_q[gi];
        assign pbuf_d[gi] = load_shift ? bus.P_data : pbuf_q[gi];
      end else begin : g_tail
        assign win_d[gi]  = scan_first ? 8'h00 : shift_en ? win_q[gi-1] : win_q[gi];
        assign pbuf_d[gi] = load_shift ? pbuf_q[gi-1] : pbuf_q[gi];
      end
      assign eq_vec[gi] = (POS >= len_q) || byte_eq(pbuf_q[gi], win_d[gi], ci_q);
    end
  endgenerate

  assign hit = shift_en && (fill_nx == len_q) && (&eq_vec);

  always_comb begin
    logic advance;
    advance   = 1'b0;
    state_d   = state_q;
    t_addr_d  = t_addr_q;
    p_addr_d  = p_addr_q;
    pat_idx_d = pat_idx_q;
    pno_d     = pno_q;
    maddr_d   = maddr_q;
    valid_d   = 1'b0;
    finish_d  = (state_q == S_DONE);
    ci_d      = ci_q;
    first_d   = first_q;
    len_d     = len_q;

    case (state_q)
      S_IDLE: begin
        state_d   = S_LOAD;
        first_d   = 1'b1;
        p_addr_d  = '0;
        pat_idx_d = '0;
      end
      S_LOAD: begin
        if (first_q) begin
          first_d  = 1'b0;
          ci_d     = bus.case_insensitive;
          len_d    = '0;
          p_addr_d = p_addr_q + PAW'(1);
        end else if (bus.P_data == 8'h00) begin
          // P_addr already points one past the terminator: the next pattern start.
          if (len_q == '0) begin
            state_d = S_DONE;
          end else if (len_q > LW'(PLEN)) begin
            advance = 1'b1;
          end else begin
            state_d  = S_SCAN;
            first_d  = 1'b1;
            t_addr_d = '0;
          end
        end else begin
          p_addr_d = p_addr_q + PAW'(1);
          if (len_q <= LW'(PLEN)) len_d = len_q + LW'(1);
        end
      end
      S_SCAN: begin
        if (first_q) begin
          first_d  = 1'b0;
          t_addr_d = t_addr_q + TAW'(1);
        end else begin
          if (hit) begin
            valid_d = 1'b1;
            pno_d   = pat_idx_q;
            maddr_d = cap_addr - TAW'(len_q) + TAW'(1);
          end
          if (text_end) advance = 1'b1;
          else          t_addr_d = t_addr_q + TAW'(1);
        end
      end
      default: ;
    endcase

    if (advance) begin
      if (pat_idx_q == {PNW{1'b1}}) begin
        state_d = S_DONE;
      end else begin
        pat_idx_d = pat_idx_q + PNW'(1);
        state_d   = S_LOAD;
        first_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      t_addr_q  <= '0;
      p_addr_q  <= '0;
      pat_idx_q <= '0;
      pno_q     <= '0;
      maddr_q   <= '0;
      valid_q   <= 1'b0;
      finish_q  <= 1'b0;
      ci_q      <= 1'b0;
      first_q   <= 1'b0;
      len_q     <= '0;
      fill_q    <= '0;
      for (int i = 0; i < PLEN; i++) begin
        win_q[i]  <= 8'h00;
        pbuf_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      t_addr_q  <= t_addr_d;
      p_addr_q  <= p_addr_d;
      pat_idx_q <= pat_idx_d;
      pno_q     <= pno_d;
      maddr_q   <= maddr_d;
      valid_q   <= valid_d;
      finish_q  <= finish_d;
      ci_q      <= ci_d;
      first_q   <= first_d;
      len_q     <= len_d;
      fill_q    <= fill_nx;
      for (int i = 0; i < PLEN; i++) begin
        win_q[i]  <= win_d[i];
        pbuf_q[i] <= pbuf_d[i];
      end
    end
  end

  assign bus.T_addr     = t_addr_q;
  assign bus.P_addr     = p_addr_q;
  assign bus.valid      = valid_q;
  assign bus.pattern_no = pno_q;
  assign bus.match_addr = maddr_q;
  assign bus.finish     = finish_q;

endmodule

// File: tb/tb_sme_param.sv
// Bench for sme_param: ROM models, a string-level reference model feeding an expected-match
// queue, and a monitor that pops and compares on every valid strobe.
module tb_sme_param;
  localparam int TAW  = 12;
  localparam int PAW  = 7;
  localparam int PNW  = 4;
  localparam int PLEN = 16;
  localparam int TSZ  = 1 << TAW;
  localparam int PSZ  = 1 << PAW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sme_param_if #(.TAW(TAW), .PAW(PAW), .PNW(PNW)) bus ();

  sme_param #(.TAW(TAW), .PAW(PAW), .PNW(PNW), .PLEN(PLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] text_mem [TSZ];
  logic [7:0] pat_mem  [PSZ];

  always @(posedge clk) begin
    bus.T_data <= text_mem[bus.T_addr];
    bus.P_data <= pat_mem[bus.P_addr];
  end

  logic [PNW+TAW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int pat_wr = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor: every valid strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && bus.valid) begin
      chk("valid_with_finish", {63'd0, bus.finish}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_match", {bus.pattern_no, bus.match_addr}, {(PNW+TAW){1'b1}} + 1'b1);
      end else begin
        logic [PNW+TAW-1:0] e;
        e = exp_q.pop_front();
        chk("match", {bus.pattern_no, bus.match_addr}, e);
        $display("match pattern_no=%0d match_addr=%03h", bus.pattern_no, bus.match_addr);
      end
    end
  end

  function automatic logic [7:0] fold(input logic [7:0] b, input bit ci);
    if (ci && b >= "A" && b <= "Z") return b + 8'd32;
    return b;
  endfunction

  function automatic bit beq(input logic [7:0] p, input logic [7:0] t, input bit ci);
`ifdef SME_WILDCARD_EN
    if (p == ".") return t != 8'h00;
`endif
    return fold(p, ci) == fold(t, ci);
  endfunction

  // Reference: parse the pattern list, try every text offset for each pattern.
  task automatic build_expected(input bit ci);
    int tlen, p, L;
    logic [7:0] pb [256];
    tlen = 0;
    while (tlen < TSZ && text_mem[tlen] != 8'h00) tlen++;
    p = 0;
    for (int idx = 0; idx < (1 << PNW); idx++) begin
      L = 0;
      while (pat_mem[p] != 8'h00 && L < 200) begin
        pb[L] = pat_mem[p];
        L++;
        p = (p + 1) % PSZ;
      end
      p = (p + 1) % PSZ;
      if (L == 0) break;
      if (L <= PLEN) begin
        for (int s = 0; s + L <= tlen; s++) begin
          bit ok;
          ok = 1'b1;
          for (int k = 0; k < L; k++) if (!beq(pb[k], text_mem[s+k], ci)) ok = 1'b0;
          if (ok) exp_q.push_back({PNW'(idx), TAW'(s)});
        end
      end
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < TSZ; i++) text_mem[i] = 8'h00;
    for (int i = 0; i < PSZ; i++) pat_mem[i] = 8'h00;
    pat_wr = 0;
  endtask

  task automatic set_text(input string s);
    for (int i = 0; i < s.len(); i++) text_mem[i] = s[i];
  endtask

  task automatic add_pat(input string s);
    for (int i = 0; i < s.len(); i++) pat_mem[pat_wr+i] = s[i];
    pat_wr += s.len() + 1;
  endtask

  task automatic start_run(input bit ci);
    bus.case_insensitive = ci;
    exp_q.delete();
    build_expected(ci);
    reset = 1'b0;
    #1;
    chk("reset_state", {bus.valid, bus.finish, bus.pattern_no, bus.match_addr, bus.T_addr, bus.P_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic finish_run(input string name);
    int n;
    logic [TAW-1:0] ta;
    logic [PAW-1:0] pa;
    n = 0;
    while (!bus.finish && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finish"}, {63'd0, bus.finish}, 64'd1);
    ta = bus.T_addr;
    pa = bus.P_addr;
    repeat (3) @(negedge clk);
    chk({name, "_finish_held"}, {bus.finish, bus.valid}, 64'd2);
    chk({name, "_addr_frozen"}, {bus.T_addr, bus.P_addr}, {ta, pa});
    chk({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    $display("case %s complete", name);
  endtask

  task automatic run_case(input string name, input bit ci);
    start_run(ci);
    finish_run(name);
  endtask

  string alpha;

  initial begin
    int n;
    bus.case_insensitive = 1'b0;
    alpha = "abAB.xz";
    clear_mems();
    repeat (2) @(negedge clk);

    clear_mems(); set_text("abcabc"); add_pat("abc");
    run_case("abcabc", 1'b0);

    clear_mems(); set_text("aaaa"); add_pat("aa");
    run_case("overlap", 1'b0);

    clear_mems(); set_text("HeLLo"); add_pat("hello");
    run_case("fold_on", 1'b1);
    run_case("fold_off", 1'b0);

    clear_mems(); set_text("a1b2"); add_pat("a.b");
    run_case("wildcard", 1'b0);

    clear_mems(); set_text("abz"); add_pat("zz"); add_pat("b");
    run_case("two_pats", 1'b0);

    clear_mems(); set_text("abz"); add_pat("zz"); add_pat("aaaaaaaaaaaaaaaaa"); add_pat("b");
    run_case("long_skip", 1'b0);

    clear_mems(); set_text("abc");
    run_case("empty_list", 1'b0);

    clear_mems(); set_text("ab");
    for (int i = 0; i < 18; i++) add_pat("a");
    run_case("pat_limit", 1'b0);

    clear_mems(); set_text("abcd"); add_pat("abcde");
    run_case("short_text", 1'b0);

    clear_mems();
    for (int i = 0; i < TSZ; i++) text_mem[i] = "q";
    text_mem[TSZ-3] = "x"; text_mem[TSZ-2] = "y"; text_mem[TSZ-1] = "z";
    add_pat("xyz");
    run_case("full_space", 1'b0);

    // Reset during the scan of pattern 1, then expect the whole list again.
    clear_mems(); set_text("abcabcabcabc"); add_pat("abc"); add_pat("bc"); add_pat("c");
    start_run(1'b0);
    n = 0;
    while (!(bus.valid && bus.pattern_no == PNW'(1)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pattern1", {63'd0, bus.valid}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midscan_clear", {bus.valid, bus.finish, bus.pattern_no, bus.match_addr, bus.T_addr, bus.P_addr}, 64'd0);
    exp_q.delete();
    build_expected(1'b0);
    @(negedge clk);
    reset = 1'b1;
    finish_run("midscan_rerun");

    for (int r = 0; r < 12; r++) begin
      int tlen, np, L, off;
      bit ci;
      clear_mems();
      tlen = $urandom_range(0, 40);
      for (int i = 0; i < tlen; i++) text_mem[i] = alpha[$urandom_range(0, 6)];
      np = $urandom_range(1, 4);
      for (int k = 0; k < np; k++) begin
        L = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 18) : $urandom_range(1, 4);
        off = (tlen > 0) ? $urandom_range(0, tlen - 1) : 0;
        for (int i = 0; i < L; i++) begin
          if (tlen > 0 && $urandom_range(0, 2) != 0 && L <= PLEN)
            pat_mem[pat_wr+i] = text_mem[(off + i) % tlen] == 8'h00 ? 8'h61 : text_mem[(off + i) % tlen];
          else
            pat_mem[pat_wr+i] = alpha[$urandom_range(0, 6)];
        end
        pat_wr += L + 1;
      end
      ci = 1'($urandom_range(0, 1));
      run_case($sformatf("random%0d", r), ci);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sme_param.md
SME_PARAM -- requirements
Module: sme_param

Interface
REQ-001 Parameter TAW, default 12: text ROM address width; text space is 2^TAW bytes.
REQ-002 Parameter PAW, default 7: pattern ROM address width.
REQ-003 Parameter PNW, default 4: pattern_no width; at most 2^PNW patterns are processed.
REQ-004 Parameter PLEN, default 16: maximum pattern length in bytes; range 1..32.
REQ-005 Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- case_insensitive  input  1  fold A-Z/a-z when high.
- T_addr  output  TAW  text ROM address.
- T_data  input  8  text ROM data, valid one cycle after T_addr.
- P_addr  output  PAW  pattern ROM address.
- P_data  input  8  pattern ROM data, valid one cycle after P_addr.
- valid  output  1  one-cycle match strobe.
- pattern_no  output  PNW  index of the matched pattern.
- match_addr  output  TAW  text address of the match's first byte.
- finish  output  1  all patterns done; held high.

Function
REQ-006 Pattern ROM format: patterns stored back to back from address 0, each terminated by 0x00; an empty pattern (0x00 at a pattern start) ends the list.
REQ-007 Text format: bytes from address 0, ending at the first 0x00 or after address 2^TAW-1, whichever comes first.
REQ-008 FSM states: IDLE -> LOAD -> SCAN -> (LOAD | DONE); IDLE leaves on the first clk after reset deasserts.
REQ-009 LOAD: read pattern bytes at one per cycle into a PLEN-entry buffer and record length L; case_insensitive is sampled at LOAD entry and held for the whole scan.
REQ-010 A pattern with L > PLEN is skipped: read to its terminator, produce no output, still increment pattern_no.
REQ-011 SCAN: stream text bytes at one per cycle, from address 0, into an L-deep sliding window, comparing all L positions in parallel.
REQ-012 Case folding applies to both operands when enabled; only 0x41-0x5A and 0x61-0x7A are folded.
REQ-013 Match: the window holds L text bytes and every position compares equal. Then valid=1 for exactly one cycle, match_addr = address of the window's first byte, and pattern_no = current pattern index.
REQ-014 valid is asserted in the cycle after the window's final byte is captured; overlapping matches are all reported, in ascending match_addr order.
REQ-015 Text shorter than L: no match is reported.
REQ-016 Scan ends at text end. Then advance P_addr past the terminator and return to LOAD; the 2^PNW-th pattern or an empty pattern goes to DONE.
REQ-017 DONE: finish=1 until reset, with T_addr and P_addr frozen; an empty first pattern reaches DONE with no valid pulse.
REQ-018 valid and finish are never high in the same cycle; finish rises at least one cycle after the last valid.

Reset
REQ-019 reset low clears asynchronously: FSM to IDLE, valid=0, finish=0, pattern_no=0, match_addr=0, T_addr=0, P_addr=0, window and pattern buffer cleared.
REQ-020 reset asserted mid-LOAD or mid-SCAN aborts the operation; after release the engine restarts from pattern 0, text address 0.

Configuration
REQ-021 Macro SME_WILDCARD_EN. When defined, pattern byte 0x2E ('.') matches any text byte except 0x00. When undefined, 0x2E is compared literally.

Verification
REQ-022 Text "abcabc\0", pattern "abc\0\0" -> valid with {0,0x000}, {0,0x003}; then finish.
REQ-023 Text "aaaa\0", pattern "aa\0\0" -> overlapping matches at 0x000, 0x001, 0x002 in that order.
REQ-024 Text "HeLLo\0", pattern "hello\0\0": case_insensitive=1 -> {0,0x000}; case_insensitive=0 -> no valid, finish only.
REQ-025 Text "a1b2\0", pattern "a.b\0\0". With SME_WILDCARD_EN -> {0,0x000}. Without it -> no match.
REQ-026 Two patterns "zz\0" and "b\0\0" on text "abz\0" -> only {1,0x001}; a 17-byte pattern with PLEN=16 is skipped and its index is consumed.
REQ-027 reset pulsed low during the scan of pattern 1 -> outputs clear immediately; the rerun reproduces the full expected match list with no duplicates.
